phase_sequencer: RTL
====================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 SHALL have these ports (clock and reset first):
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a 4-phase sequence; sampled in IDLE only.
- abort  input  1  terminate the sequence.
- hold  input  1  pause counting.
- loop  input  1  restart at phase 0 after phase 3.
- durs  input  12  phase durations; durs[3p+2:3p] = phase p.
- cDone  input  1  done flag from the downstream 3-bit load/count counter.
- ldEn  output  1  counter load enable.
- value  output  3  counter load value.
- cEn  output  1  counter count enable.
- phase  output  2  current phase index.
- busy  output  1  high when not IDLE.
- cycleDone  output  1  one-cycle pulse at the end of phase 3.
- err  output  1  sticky watchdog error.

Function
REQ-003 SHALL implement the states IDLE, LOAD, COUNT and NEXT.
REQ-004 IDLE: start=1 at an edge SHALL latch durs into internal registers, set phase=0, clear err, and go to LOAD.
REQ-005 LOAD (one cycle): ldEn=1, value=latched duration of current phase.
- Duration nonzero: go to COUNT.
- Duration 0: go directly to NEXT (phase skipped; the counter treats 0 as 8 counts).
REQ-006 COUNT: cEn SHALL be combinational (state==COUNT) & ~hold & ~cDone; go to NEXT on the first edge where cDone=1.
REQ-007 cDone SHALL be ignored in all states except COUNT, since a stale cDone persists through LOAD.
REQ-008 NEXT (one cycle), phase<3: phase increments and the state goes to LOAD.
REQ-009 NEXT, phase==3: cycleDone=1 for that cycle; then:
- loop=1: phase=0, go to LOAD.
- loop=0: go to IDLE.
REQ-010 Per-phase latency with no hold SHALL be d+3 cycles (LOAD 1, COUNT d+1, NEXT 1); a skipped phase takes 2 cycles.
REQ-011 Each hold cycle in COUNT SHALL extend the phase by one cycle; hold in other states has no effect.
REQ-012 abort=1 in any non-IDLE state SHALL force IDLE at the next edge. abort wins over a simultaneous cDone, loop or hold.
REQ-013 start while busy SHALL be ignored; durs changes while busy SHALL be ignored.
REQ-014 busy SHALL be registered-state derived: busy = (state != IDLE).
REQ-015 ldEn and cEn SHALL never be high in the same cycle.
REQ-016 value SHALL be 0 whenever ldEn=0.

Reset
REQ-017 rst_n=0 at an edge SHALL set state=IDLE, phase=0, latched durations=0, err=0 and watchdog=0.
REQ-018 During and after reset: ldEn=0, cEn=0, value=0, busy=0, cycleDone=0.
REQ-019 Reset SHALL override start and abort, including when asserted mid-sequence.

Configuration
REQ-020 Macro PHASE_TIMEOUT_EN defined:
- A 4-bit watchdog counts COUNT cycles with cEn=1 and clears on entering LOAD.
- On reaching 15 without cDone, set err=1 (sticky until the next accepted start or reset) and go to IDLE.
REQ-021 Macro PHASE_TIMEOUT_EN undefined: no watchdog logic; err is tied to 0; COUNT waits for cDone indefinitely.

Verification
REQ-022 durs={4,3,2,1} (phase3..0), loop=0, start pulse at edge E0 -> cycleDone high only in cycle 22 after E0; busy low from cycle 23; phase sequence 0,1,2,3.
REQ-023 durs=all 0, start -> each phase is LOAD then NEXT; cycleDone in cycle 8; cEn never high.
REQ-024 durs phase0=3, hold high for 2 cycles mid-COUNT -> phase 0 lasts 8 cycles; the counter receives exactly 3 cEn pulses.
REQ-025 abort asserted in the same cycle as cDone during COUNT of phase 1 -> IDLE next cycle; no cycleDone; phase stays 1 until the next start.
REQ-026 loop=1, durs all 1 -> cycleDone every 16 cycles; rst_n=0 mid-phase-2 -> all outputs 0 next cycle.
REQ-027 PHASE_TIMEOUT_EN defined, cDone tied 0, durs phase0=3 -> err=1 and busy=0 from cycle 17 after E0; macro undefined -> busy stays 1, err=0.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if -- control/status bundle between the phase sequencer and
// whoever drives it (controller side) plus the downstream load/count counter.
//
//   start     controller -> seq   begin a 4-phase sequence (sampled in IDLE)
//   abort     controller -> seq   terminate the running sequence
//   hold      controller -> seq   pause counting while in COUNT
//   loop      controller -> seq   restart at phase 0 after phase 3
//   durs      controller -> seq   phase durations, durs[3p+2:3p] = phase p
//   cDone     counter    -> seq   done flag from the 3-bit load/count counter
//   ldEn      seq -> counter      counter load enable
//   value     seq -> counter      counter load value (0 when ldEn=0)
//   cEn       seq -> counter      counter count enable
//   phase     seq -> controller   current phase index
//   busy      seq -> controller   sequencer not IDLE
//   cycleDone seq -> controller   one-cycle pulse at the end of phase 3
//   err       seq -> controller   sticky watchdog error
//
// master = the driving side (testbench / controller), slave = the sequencer.
interface phase_sequencer_if;
    logic        start;
    logic        abort;
    logic        hold;
    logic        loop;
    logic [11:0] durs;
    logic        cDone;
    logic        ldEn;
    logic [2:0]  value;
    logic        cEn;
    logic [1:0]  phase;
    logic        busy;
    logic        cycleDone;
    logic        err;

    modport master (
        output start, abort, hold, loop, durs, cDone,
        input  ldEn, value, cEn, phase, busy, cycleDone, err
    );

    modport slave (
        input  start, abort, hold, loop, durs, cDone,
        output ldEn, value, cEn, phase, busy, cycleDone, err
    );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer -- steps a downstream 3-bit load/count counter through four
// phases. Each phase loads its latched duration into the counter (LOAD),
// counts it down (COUNT, until cDone), then advances (NEXT). A zero duration
// skips the phase (LOAD -> NEXT). After phase 3 the sequence either loops
// back to phase 0 or returns to IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    phase_sequencer_if.slave (start/abort/hold/loop/durs/cDone in,
//          ldEn/value/cEn/phase/busy/cycleDone/err out)
//
// Optional build macro PHASE_TIMEOUT_EN: adds a 4-bit watchdog on COUNT.
// Fifteen counting cycles without cDone set the sticky err flag and drop the
// sequencer back to IDLE. Without the macro err is tied low and COUNT waits
// for cDone indefinitely.
module phase_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    phase_sequencer_if.slave   bus
);

    localparam int NUM_PHASES = 4;
    localparam int DUR_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        NEXT  = 2'd3
    } state_t;

    state_t                              state;
    logic [1:0]                          phase_q;
    logic [NUM_PHASES-1:0][DUR_W-1:0]    dur_q;
    logic [DUR_W-1:0]                    cur_dur;
    logic                                cen;
    logic                                last_phase;

`ifdef PHASE_TIMEOUT_EN
    localparam logic [3:0] WD_LIMIT = 4'd15;
    logic [3:0] wd_q;
    logic       err_q;
`endif

    assign cur_dur    = dur_q[phase_q];
    assign last_phase = (phase_q == 2'(NUM_PHASES - 1));

    // cDone only matters in COUNT; a stale done from the previous phase is
    // still visible during LOAD and must not stop the counter there.
    assign cen = rst_n & (state == COUNT) & ~bus.hold & ~bus.cDone;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase_q <= 2'd0;
            dur_q   <= '0;
`ifdef PHASE_TIMEOUT_EN
            wd_q    <= 4'd0;
            err_q   <= 1'b0;
`endif
        end else if (state != IDLE && bus.abort) begin
            // abort beats cDone, loop and hold; phase is left as-is
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dur_q   <= bus.durs;
                        phase_q <= 2'd0;
`ifdef PHASE_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state   <= LOAD;
                    end
                end
                LOAD: begin
`ifdef PHASE_TIMEOUT_EN
                    wd_q <= 4'd0;
`endif
                    // zero duration would be 8 counts downstream; skip it
                    state <= (cur_dur != '0) ? COUNT : NEXT;
                end
                COUNT: begin
                    if (bus.cDone) begin
                        state <= NEXT;
                    end
`ifdef PHASE_TIMEOUT_EN
                    else if (cen) begin
                        wd_q <= wd_q + 4'd1;
                        if (wd_q == WD_LIMIT - 4'd1) begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
`endif
                end
                NEXT: begin
                    if (!last_phase) begin
                        phase_q <= phase_q + 2'd1;
                        state   <= LOAD;
                    end else if (bus.loop) begin
                        phase_q <= 2'd0;
                        state   <= LOAD;
                    end else begin
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; rst_n gating keeps them low for
    // the whole reset cycle, not just after the reset edge.
    assign bus.ldEn      = rst_n & (state == LOAD);
    assign bus.value     = (rst_n && state == LOAD) ? cur_dur : '0;
    assign bus.cEn       = cen;
    assign bus.phase     = phase_q;
    assign bus.busy      = rst_n & (state != IDLE);
    assign bus.cycleDone = rst_n & (state == NEXT) & last_phase;
`ifdef PHASE_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
